// File: rtl/countdown_ctrl.sv
// Run controller for the two-digit BCD countdown: idle/run/pause/done sequencing,
// one-second prescaler, and time-multiplexed 7-segment drive for both digits.
module countdown_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clr,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  output logic [6:0] q,
  output logic [1:0] an,
  output logic       q2,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          sel_q, sel_d;

  logic [3:0]    loadTens, loadOnes;
  logic          doStep;
  logic [3:0]    digit;

  assign loadTens = (preset_tens > 4'd9) ? 4'd9 : preset_tens;
  assign loadOnes = (preset_ones > 4'd9) ? 4'd9 : preset_ones;

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      pre_q   <= '0;
      scan_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
    end
  end

  // The resume edge counts as a running edge, so a pause lasting P cycles
  // delays completion by exactly P cycles.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    pre_d   = pre_q;
    doStep  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      pre_d   = '0;
    end else if (start) begin
      tens_d  = loadTens;
      ones_d  = loadOnes;
      pre_d   = '0;
      state_d = (loadTens == 4'd0 && loadOnes == 4'd0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) state_d = PAUSE;
          else       doStep  = 1'b1;
        end
        PAUSE: begin
          if (pause) begin
            state_d = RUN;
            doStep  = 1'b1;
          end
        end
        default: ;
      endcase
      if (doStep) begin
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
          if (tens_q == 4'd0 && ones_q == 4'd1) state_d = DONE;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end
  end

  assign digit = sel_q ? tens_q : ones_q;

  always_comb begin
    q = 7'h00;
    case (digit)
      4'd0: q = 7'h3F;
      4'd1: q = 7'h06;
      4'd2: q = 7'h5B;
      4'd3: q = 7'h4F;
      4'd4: q = 7'h66;
      4'd5: q = 7'h6D;
      4'd6: q = 7'h7D;
      4'd7: q = 7'h07;
      4'd8: q = 7'h7F;
      4'd9: q = 7'h6F;
      default: q = 7'h00;
    endcase
  end

  assign an   = sel_q ? 2'b10 : 2'b01;
  assign q2   = (state_q == DONE);
  assign busy = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Run controller for the two-digit 99-second countdown display. Sequences a BCD down-counter through idle, run, pause and done states from start/pause/clear pulses, derives the one-second tick from the system clock, and time-multiplexes both digits onto one shared 7-segment output. The done LED is driven from the same block. It sits between the debounced push-button logic and the board's segment and anode pins.

## Interface
- TICK_DIV, 50_000_000: clkIn cycles per countdown step (≥2).
- SCAN_DIV, 50_000: clkIn cycles per digit-scan slot (≥2).
- clkIn  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle pulse: load preset and run.
- pause  input  1  single-cycle pulse: toggle RUN/PAUSE.
- clr  input  1  synchronous clear to IDLE.
- preset_tens  input  4  BCD tens of start value.
- preset_ones  input  4  BCD ones of start value.
- q  output  7  segments {g,f,e,d,c,b,a}, active-high.
- an  output  2  digit enable, active-high; an[0] ones, an[1] tens.
- q2  output  1  done LED.
- busy  output  1  high in RUN or PAUSE.

## Operation
- Reset values: state=IDLE, count=00, pre=0, scan=0, sel=0; therefore q=7'h3F, an=2'b01, q2=0, busy=0.
- Preset digits >9 are clamped to 9 at load.
- Edge priority: rst > clr > start > pause.
- IDLE: count holds. start → count←clamped preset, pre←0, RUN. pause ignored.
- RUN, each edge with no higher-priority event: if pre==TICK_DIV-1 then pre←0 and count decrements BCD (ones 0→9 with tens−1); otherwise pre←pre+1. A decrement that reaches 00 moves to DONE on the same edge.
- RUN + pause → PAUSE; count and pre hold. Pause takes priority over a tick due on the same edge, so no decrement occurs.
- PAUSE: count and pre hold. pause → RUN, and the prescaler resumes from its held value. start → reload and RUN.
- DONE: count=00, q2=1. start → reload and RUN. pause ignored.
- start with preset 00, from any state → count=00, state DONE on that edge (no RUN cycles).
- start in RUN or PAUSE: restarts from preset with pre←0.
- clr from any state → IDLE, count←00, pre←0. Scan counter is unaffected.
- Display: scan counter counts 0..SCAN_DIV-1 in every state. On wrap, sel toggles.
- an = sel ? 2'b10 : 2'b01.
- q = segment code of count ones (sel=0) or tens (sel=1), decoded combinationally from registered sel/count.
- Segment codes 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- q2 = (state==DONE). busy = (state==RUN || state==PAUSE).

## Timing
- start sampled at edge k with preset N≠0: busy high after edge k. Decrements occur at edges k+TICK_DIV, k+2·TICK_DIV, and so on. DONE and q2=1 follow edge k+N·TICK_DIV.
- A pause held for P cycles in total extends DONE by exactly P cycles.
- Digit slot length is exactly SCAN_DIV cycles; an changes on the edge after scan==SCAN_DIV-1.
- q follows count/sel with zero added latency (combinational decode).
- rst assertion forces all reset values immediately, without waiting for a clock edge. Release mid-countdown leaves the block in IDLE with count 00.

## Test plan
Bench uses TICK_DIV=4 and SCAN_DIV=3.
- Reset: rst=1 for 5 cycles → q=3F, an=01, q2=0, busy=0. Release → an toggles every 3 cycles; q alternates ones/tens, both 3F.
- Countdown: preset 1/2 (12), start at edge k → count=11 at k+4, 10 at k+8, 09 at k+12, 00 and q2=1 at k+48; busy falls on the same edge.
- Pause: preset 03, start, pause at k+2, pause again 10 cycles later → decrements at k+14, k+18, k+22. Pause pulse on a tick edge → no decrement.
- Boundaries: preset 0/0 start → DONE next edge, busy never high. Preset F/F → loads 99; the tens digit selected shows 6F. Simultaneous start+pause in IDLE → RUN.
- Restart and clear: start during RUN at count 05 with preset 07 → count=07, pre=0. clr during PAUSE → IDLE, count 00, q2=0.
- Async reset mid-run: assert rst between edges → outputs reach reset values before the next clkIn edge.
